uart_rx_to_mem: RTL and testbench
=================================

Name: uart_rx_to_mem

Overview:
- Upstream loader for the matrix multiplier: receives operand bytes on the UART line and writes them into the operand memories, matrix A first, then matrix B.
- Pulses load_done when both matrices are complete so the multiply/control stage can start; results later leave through the memory-to-TX stage.
- The full 8N1 receiver (oversampled bit timing) lives inside this block.

Parameters:
- CLKS_PER_BIT, 868: clocks per UART bit (100 MHz / 115200).
- N, 3: matrix dimension; each matrix holds N*N byte elements.
- AW, 4: element address width; must satisfy 2**AW >= N*N.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- rx_data  in  1  UART serial input; idle high; asynchronous to clk.
- restart  in  1  synchronous; clears element counter to 0 (next byte goes to A[0]).
- mem_we  out  1  one-cycle write strobe.
- mem_sel  out  1  0 = matrix A, 1 = matrix B.
- mem_addr  out  AW  element address, row-major, 0..N*N-1.
- mem_wdata  out  8  received byte.
- load_done  out  1  one-cycle pulse after the final B element is written.
- frame_err  out  1  sticky; set on a bad stop bit; cleared by restart or reset.

Behaviour:
- Reset (rst=0): all outputs 0; synchronizer flops 1; FSM IDLE; bit, element and clock counters 0.
- rx_data passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- FSM states: IDLE, START, DATA, STOP, WRITE, WAIT_HIGH.
- IDLE -> START when the synchronized line is 0.
- START: at CLKS_PER_BIT/2 (integer division), re-sample the line.
  - 0: go to DATA and reset the clock counter.
  - 1: glitch; return to IDLE with no output.
- DATA: sample every CLKS_PER_BIT clocks; bits are shifted in LSB first. After 8 bits go to STOP.
- STOP: sample after CLKS_PER_BIT clocks.
  - 1: go to WRITE.
  - 0: set frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until the line samples 1, then go to IDLE. A held-low break line therefore never triggers repeated frames.
- WRITE: single cycle.
  - mem_we=1, mem_wdata=byte.
  - idx < N*N: mem_sel=0, mem_addr=idx. Otherwise mem_sel=1, mem_addr=idx-N*N.
  - Then go to IDLE.
  - mem_sel, mem_addr and mem_wdata are valid only while mem_we=1 and hold their values otherwise.
- Element counter idx runs 0..2*N*N-1.
  - Increments on every WRITE.
  - On the WRITE with idx=2*N*N-1: idx wraps to 0 and load_done pulses in the following cycle. The next byte starts a new A load.
- Latency: mem_we rises exactly 1 clk after the stop-bit mid-sample, roughly 9.5 bit times after the start edge.
- restart:
  - In the same cycle as WRITE, the write still occurs and idx goes to 0, not idx+1.
  - Mid-frame, restart does not abort the frame; it only clears idx and frame_err.
- rst asserted mid-frame: immediate return to the reset state; the partial byte is lost and no write is issued.
- Back-to-back frames (stop bit directly followed by a start bit) must be received: WRITE lasts 1 cycle, and IDLE catches the start bit within the first half-bit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit is expected between D7 and the stop bit, and a PARITY state is added after DATA.
  - New output parity_err (1 bit, sticky, cleared like frame_err).
  - On a parity mismatch the byte is discarded with no write and no idx increment, and the FSM goes to WAIT_HIGH.
- Undefined: 8N1 framing only; the parity_err port does not exist.

Decomposition:
- Shared header/package mat_pkg:
  - Constants CLKS_PER_BIT and N, and the AW derivation (clog2 of N*N).
  - FSM state encodings.
  - UART_RX_PARITY_EN default.
  - The TX side reuses the same constants.
- One sub-module, uart_rx_core: synchronizer, START/DATA/(PARITY)/STOP/WAIT_HIGH timing.
  - Outputs byte_valid (1-cycle pulse), byte and frame_err_pulse.
- uart_rx_to_mem keeps the element counter, A/B steering, WRITE strobe, load_done and the sticky flags.

Test Plan:
- Bench settings CLKS_PER_BIT=16, N=2.
- Test 1: send 0x01..0x08 as 8N1 frames.
  - Required writes: A[0..3]=01,02,03,04 (sel=0) and B[0..3]=05,06,07,08 (sel=1).
  - load_done: one pulse, one cycle after the write of 08; idx back to 0.
- Test 2: send 0xA5 with a 0 stop bit, then hold the line low for 40 clks, then send 0x3C.
  - Required: frame_err=1, no write for 0xA5, 0x3C written to A[0].
- Test 3: a 4-clock low glitch on an idle line -> no write, FSM back in IDLE, frame_err stays 0.
- Test 4: send 3 bytes, pulse restart, then send 0x77 -> 0x77 written to A[0], frame_err cleared.
- Test 5: assert rst during the DATA bits of 0xFF -> outputs 0 immediately, no write. The next frame 0x11 is written to A[0].
- Test 6: with UART_RX_PARITY_EN defined, send 0x03 with parity bit 1 (wrong; even parity expects 0).
  - Required: parity_err=1 and no write.
  - Then 0x03 with parity bit 0 is written to A[0].

Source files
------------

// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared loader/TX constants and receiver FSM encoding.
// UART_RX_PARITY_EN selects 8E1 framing (one even-parity bit before the stop bit).
package mat_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int N_DEF            = 3;
  localparam int AW_DEF           = $clog2(N_DEF * N_DEF);

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WRITE     = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - synchronised UART receiver with mid-bit sampling and break handling.
// UART_RX_PARITY_EN adds the PARITY state and parity_err_pulse.
module uart_rx_core
  import mat_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err_pulse
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err_pulse
`endif
);

  localparam int            CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rx_s, tick, half_tick, par_ok;

  assign rx_s      = sync2_q;
  assign tick      = (cnt_q == FULL_M1);
  assign half_tick = (cnt_q == HALF_M1);
  assign par_ok    = (rx_s == ^shreg_q);
  assign rx_byte   = shreg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      sync1_q <= rx_data;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!rx_s) state_d = ST_START;
      ST_START:     if (half_tick) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (tick && bit_q == 3'd7) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (tick) state_d = par_ok ? ST_STOP : ST_WAIT_HIGH;
      ST_STOP:      if (tick) state_d = rx_s ? ST_WRITE : ST_WAIT_HIGH;
      ST_WRITE:     state_d = ST_IDLE;
      ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Clock counter restarts at each sample point so every later sample lands mid-bit.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      ST_START: if (half_tick) cnt_d = '0;
      ST_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          shreg_d = {rx_s, shreg_q[7:1]};
        end
      end
      ST_PARITY, ST_STOP: if (tick) cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    byte_valid      = 1'b0;
    frame_err_pulse = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_pulse = (state_q == ST_PARITY) && tick && !par_ok;
`endif
    if (state_q == ST_STOP && tick) begin
      byte_valid      = rx_s;
      frame_err_pulse = !rx_s;
    end
  end

endmodule

// File: rtl/uart_rx_to_mem.sv
// rtl/uart_rx_to_mem.sv - steers received bytes into operand memories A then B, pulses load_done.
// UART_RX_PARITY_EN adds the sticky parity_err output.
module uart_rx_to_mem
  import mat_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int N            = N_DEF,
  parameter int AW           = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_data,
  input  logic          restart,
  output logic          mem_we,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          load_done,
  output logic          frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic          parity_err
`endif
);

  localparam logic [AW:0] IDX_NN   = (AW + 1)'(N * N);
  localparam logic [AW:0] IDX_LAST = (AW + 1)'(2 * N * N - 1);
  localparam logic [AW:0] IDX_ONE  = (AW + 1)'(1);

  logic          byte_valid, frame_err_pulse;
  logic [7:0]    rx_byte;
  logic          mem_we_q, mem_we_d, mem_sel_q, mem_sel_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          load_done_q, load_done_d, frame_err_q, frame_err_d;
  logic [AW:0]   idx_q, idx_d;
`ifdef UART_RX_PARITY_EN
  logic          parity_err_pulse, parity_err_q, parity_err_d;
`endif

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .byte_valid      (byte_valid),
    .rx_byte         (rx_byte),
    .frame_err_pulse (frame_err_pulse)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_pulse(parity_err_pulse)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      idx_q       <= '0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
      idx_q       <= idx_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // idx advances during the WRITE cycle itself, so a restart seen there still wins.
  always_comb begin
    mem_we_d    = byte_valid;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (byte_valid) begin
      mem_wdata_d = rx_byte;
      if (idx_q < IDX_NN) begin
        mem_sel_d  = 1'b0;
        mem_addr_d = idx_q[AW-1:0];
      end else begin
        mem_sel_d  = 1'b1;
        mem_addr_d = AW'(idx_q - IDX_NN);
      end
    end

    idx_d = idx_q;
    if (mem_we_q) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
    if (restart) idx_d = '0;
    load_done_d = mem_we_q && (idx_q == IDX_LAST);

    frame_err_d = restart ? 1'b0 : frame_err_q;
    if (frame_err_pulse) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
    parity_err_d = restart ? 1'b0 : parity_err_q;
    if (parity_err_pulse) parity_err_d = 1'b1;
`endif
  end

  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign load_done = load_done_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_to_mem.sv
// tb/tb_uart_rx_to_mem.sv - randomized self-checking bench for uart_rx_to_mem against a write-list model.
module tb_uart_rx_to_mem;
  import mat_pkg::*;

  localparam int CPB = 16;
  localparam int N   = 2;
  localparam int NN  = N * N;
  localparam int AW  = 2;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_data = 1'b1;
  logic          restart = 1'b0;
  logic          mem_we, mem_sel, load_done, frame_err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int   n_checks = 0;
  int   n_fail = 0;
  wr_t  got_q[$];
  wr_t  exp_q[$];
  int   m_idx = 0;
  int   exp_done = 0;
  int   done_cnt = 0;
  int   done_bad = 0;
  logic we_prev = 1'b0;
  wr_t  prev_wr = '0;

  uart_rx_to_mem #(.CLKS_PER_BIT(CPB), .N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .load_done (load_done),
    .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Observer: log every write; a load_done pulse must follow the B[NN-1] write by one cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (load_done) begin
        done_cnt++;
        if (!(we_prev && prev_wr.sel && prev_wr.addr == AW'(NN - 1))) done_bad++;
      end
      if (mem_we) begin
        prev_wr = wr_t'{sel: mem_sel, addr: mem_addr, data: mem_wdata};
        got_q.push_back(prev_wr);
      end
      we_prev = mem_we;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected test sequence to complete");
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx_data = v;
    tick_n(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit = 1'b1, input logic bad_par = 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ bad_par);
`else
    if (bad_par) $display("note: no parity bit in 8N1 framing");
`endif
    drive_bit(stop_bit);
    rx_data = 1'b1;
  endtask

  task automatic pulse_restart;
    restart = 1'b1;
    tick_n(1);
    restart = 1'b0;
    m_idx = 0;
  endtask

  // Model: element k of the 2*N*N load goes to A[k] for k < N*N, else B[k-N*N].
  task automatic model_byte(input logic [7:0] b);
    exp_q.push_back(wr_t'{sel: (m_idx >= NN), addr: AW'(m_idx % NN), data: b});
    if (m_idx == 2 * NN - 1) begin
      m_idx = 0;
      exp_done++;
    end else begin
      m_idx++;
    end
  endtask

  task automatic clear_obs;
    got_q.delete();
    exp_q.delete();
    exp_done = 0;
    done_cnt = 0;
    done_bad = 0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx_data = 1'b1;
    tick_n(3);
    n_checks++;
    if ({mem_we, mem_sel, mem_addr, mem_wdata, load_done, frame_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b sel=%b addr=%0d data=%h done=%b ferr=%b, expected all 0",
               mem_we, mem_sel, mem_addr, mem_wdata, load_done, frame_err);
    end
    n_checks++;
    if ({dut.u_core.sync1_q, dut.u_core.sync2_q} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_sync: got %b%b, expected 11", dut.u_core.sync1_q, dut.u_core.sync2_q);
    end
`ifdef UART_RX_PARITY_EN
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_parity_err: got %b, expected 0", parity_err);
    end
`endif
    rst = 1'b1;
    tick_n(4);
  endtask

  task automatic test_fill_ab;
    clear_obs();
    pulse_restart();
    for (int i = 1; i <= 2 * NN + 1; i++) begin
      send_frame(8'(i));
      model_byte(8'(i));
      tick_n(2);
    end
    tick_n(8);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL fill_ab count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fill_ab write %0d: got sel=%0d addr=%0d data=%h, expected sel=%0d addr=%0d data=%h",
                 i, got_q[i].sel, got_q[i].addr, got_q[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
    n_checks++;
    if (done_cnt != exp_done || done_bad != 0) begin
      n_fail++;
      $display("FAIL fill_ab load_done: got %0d pulses (%0d mistimed), expected %0d well-timed",
               done_cnt, done_bad, exp_done);
    end
  endtask

  task automatic test_frame_err;
    logic [7:0] b;
    clear_obs();
    pulse_restart();
    send_frame(8'hA5, 1'b0);
    rx_data = 1'b0;
    tick_n(40);
    rx_data = 1'b1;
    tick_n(CPB);
    n_checks++;
    if (frame_err !== 1'b1 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_err set: got ferr=%b writes=%0d, expected ferr=1 writes=0", frame_err, got_q.size());
    end
    b = 8'h3C;
    send_frame(b);
    model_byte(b);
    tick_n(8);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL frame_err recovery: got %0d writes first=%h, expected 1 write %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : wr_t'('0), exp_q[0]);
    end
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_err sticky: got %b, expected 1", frame_err);
    end
  endtask

  task automatic test_glitch;
    logic [7:0] b;
    clear_obs();
    pulse_restart();
    rx_data = 1'b0;
    tick_n(4);
    rx_data = 1'b1;
    tick_n(40);
    n_checks++;
    if (dut.u_core.state_q !== ST_IDLE || got_q.size() != 0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch: got state=%0d writes=%0d ferr=%b, expected IDLE, 0 writes, ferr=0",
               dut.u_core.state_q, got_q.size(), frame_err);
    end
    b = 8'($urandom);
    send_frame(b);
    model_byte(b);
    tick_n(8);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL glitch follow-up: got %0d writes, expected 1 write %h", got_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_restart;
    logic [7:0] b;
    clear_obs();
    pulse_restart();
    send_frame(8'($urandom), 1'b0);
    tick_n(CPB);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_frame(b);
      model_byte(b);
      tick_n($urandom_range(0, 20));
    end
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL restart pre: got ferr=%b, expected 1", frame_err);
    end
    pulse_restart();
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL restart clears frame_err: got %b, expected 0", frame_err);
    end
    send_frame(8'h77);
    model_byte(8'h77);
    tick_n(8);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL restart count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL restart write %0d: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    clear_obs();
    pulse_restart();
    for (int i = 0; i < NN + 1; i++) begin
      b = 8'($urandom) | 8'h01;
      send_frame(b);
      model_byte(b);
    end
    tick_n(4);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    tick_n(5);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_we, mem_sel, mem_addr, mem_wdata, load_done, frame_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got sel=%b addr=%0d data=%h, expected all 0", mem_sel, mem_addr, mem_wdata);
    end
    tick_n(3);
    rst = 1'b1;
    m_idx = 0;
    tick_n(3 * CPB);
    send_frame(8'h11);
    model_byte(8'h11);
    tick_n(8);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_mid count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid write %0d: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    clear_obs();
    pulse_restart();
    for (int i = 0; i < 2 * NN + 3; i++) begin
      b = 8'($urandom);
      send_frame(b);
      model_byte(b);
    end
    tick_n(8);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL back_to_back count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back write %0d: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_cnt != exp_done || done_bad != 0) begin
      n_fail++;
      $display("FAIL back_to_back load_done: got %0d (%0d mistimed), expected %0d", done_cnt, done_bad, exp_done);
    end
  endtask

  task automatic test_random_gaps;
    logic [7:0] b;
    clear_obs();
    pulse_restart();
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom);
      send_frame(b);
      model_byte(b);
      tick_n($urandom_range(1, 3 * CPB));
      if ($urandom_range(0, 5) == 0) pulse_restart();
    end
    tick_n(8);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_gaps count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_gaps write %0d: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_cnt != exp_done || done_bad != 0) begin
      n_fail++;
      $display("FAIL random_gaps load_done: got %0d (%0d mistimed), expected %0d", done_cnt, done_bad, exp_done);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    clear_obs();
    pulse_restart();
    send_frame(8'h03, 1'b1, 1'b1);
    tick_n(CPB);
    n_checks++;
    if (parity_err !== 1'b1 || got_q.size() != 0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity bad: got perr=%b writes=%0d ferr=%b, expected perr=1 writes=0 ferr=0",
               parity_err, got_q.size(), frame_err);
    end
    send_frame(8'h03);
    model_byte(8'h03);
    tick_n(8);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL parity good: got %0d writes, expected 1 write %h", got_q.size(), exp_q[0]);
    end
    pulse_restart();
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity clear: got %b, expected 0", parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_ab();
    test_frame_err();
    test_glitch();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_random_gaps();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
